// File: rtl/uart_pkg.sv
// Shared definitions for the byte-serial packet link.
// Used by both the receiver and packet_sender.
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam int DEF_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte deserialiser with synchroniser and break handling.
// Strobes fire in the cycle of the stop-bit sample.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              rxd,
    output logic [BYTE_W-1:0] data,
    output logic              byte_valid,
    output logic              frame_err,
    output logic              idle
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

    logic              rs_meta;
    logic              rs;
    rx_state_t         state;
    logic [TW-1:0]     timer;
    logic [2:0]        bit_idx;
    logic [BYTE_W-1:0] shifter;
    logic              stop_tick;

    assign stop_tick  = (state == STOP) && (timer == T_FULL);
    assign byte_valid = stop_tick && rs;
    assign frame_err  = stop_tick && !rs;
    assign idle       = (state == IDLE);
    assign data       = shifter;

    // Two-flop synchroniser, idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta <= 1'b1;
            rs      <= 1'b1;
        end else begin
            rs_meta <= rxd;
            rs      <= rs_meta;
        end
    end

    // Bit timing and framing state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shifter <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    timer <= '0;
                    if (enable && !rs) begin
                        state <= START;
                    end
                end
                START: begin
                    if (timer == T_HALF) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= rs ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == T_FULL) begin
                        timer   <= '0;
                        shifter <= {rs, shifter[BYTE_W-1:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == T_FULL) begin
                        timer <= '0;
                        state <= rs ? IDLE : BREAK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BREAK: begin
                    timer <= '0;
                    if (rs) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_packet_rx.sv
// Packet assembler on top of the byte deserialiser.
// Adds slot counting, inter-byte timeout and the ready strobe.
module uart_packet_rx
    import uart_pkg::*;
#(
    parameter int PACKET_SIZE  = 4,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int TIMEOUT_CLKS = 10 * CLKS_PER_BIT * 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          rxd,
    output logic [BYTE_W*PACKET_SIZE-1:0] packet,
    output logic                          ready,
    output logic                          frame_err,
    output logic                          busy
);

    localparam int PW = BYTE_W * PACKET_SIZE;
    localparam int CW = $clog2(PACKET_SIZE + 1);
    localparam int IW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] C_LAST = CW'(PACKET_SIZE - 1);
    localparam logic [IW-1:0] I_LAST = IW'(TIMEOUT_CLKS - 1);

    logic [BYTE_W-1:0] data;
    logic              byte_valid;
    logic              byte_err;
    logic              rx_idle;
    logic [CW-1:0]     byte_cnt;
    logic [IW-1:0]     idle_cnt;
    logic [PW-1:0]     assembly;
    logic [PW-1:0]     asm_next;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .rxd       (rxd),
        .data      (data),
        .byte_valid(byte_valid),
        .frame_err (byte_err),
        .idle      (rx_idle)
    );

    assign busy = !rx_idle || (byte_cnt != '0);

    // Assembly register with the incoming byte dropped into its slot.
    always_comb begin
        asm_next = assembly;
        asm_next[int'(byte_cnt)*BYTE_W +: BYTE_W] = data;
    end

    // Slot counting, packet hand-off, error strobe and timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            assembly  <= '0;
            packet    <= '0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
        end else begin
            ready     <= 1'b0;
            frame_err <= 1'b0;
            idle_cnt  <= '0;
            if (byte_valid) begin
                assembly <= asm_next;
                if (byte_cnt == C_LAST) begin
                    packet   <= asm_next;
                    ready    <= 1'b1;
                    byte_cnt <= '0;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (byte_err) begin
                frame_err <= 1'b1;
                byte_cnt  <= '0;
            end else if (rx_idle && byte_cnt != '0) begin
                if (idle_cnt == I_LAST) begin
                    byte_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Self-checking bench for uart_packet_rx.
// Packet table plus hand-written corner sequences, queue scoreboard.
module tb_uart_packet_rx;

    localparam int CPB = 16;
    localparam int PS  = 4;
    localparam int TO  = 640;
    localparam int PW  = 8 * PS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          rxd = 1'b1;
    logic [PW-1:0] packet;
    logic          ready;
    logic          frame_err;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int fe_seen = 0;
    logic [PW-1:0] exp_q[$];

    typedef struct {
        logic [PW-1:0] word;
    } vec_t;

    vec_t vecs[5];

    uart_packet_rx #(
        .PACKET_SIZE (PS),
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .rxd      (rxd),
        .packet   (packet),
        .ready    (ready),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every ready pops one expected packet.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) fe_seen++;
            if (ready && frame_err) begin
                check("ready_and_frame_err", 1, 0);
            end
            if (ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", {32'h0, packet}, 64'h0);
                end else begin
                    check("packet", {32'h0, packet}, {32'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_clks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(logic [7:0] b, logic stop);
        rxd = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clks(CPB);
        end
        rxd = stop;
        wait_clks(CPB);
    endtask

    task automatic send_partial(logic [7:0] b, int nbits);
        rxd = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < nbits; i++) begin
            rxd = b[i];
            wait_clks(CPB);
        end
    endtask

    task automatic send_word(logic [PW-1:0] w);
        for (int i = 0; i < PS; i++) begin
            send_byte(w[8*i +: 8], 1'b1);
        end
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            wait_clks(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        vecs[0].word = 32'h44332211;
        vecs[1].word = 32'hFF00FF00;
        vecs[2].word = 32'h00000000;
        vecs[3].word = 32'hDEADBEEF;
        vecs[4].word = 32'h817E0180;

        // reset state
        wait_clks(3);
        check("rst_packet", packet, 0);
        check("rst_ready", ready, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        wait_clks(5);
        check("idle_busy", busy, 0);

        // nominal table
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(vecs[i].word);
            send_word(vecs[i].word);
            wait_drain("nominal_drain");
            wait_clks(4);
            check("nominal_busy", busy, 0);
        end
        check("nominal_last", packet, 32'h817E0180);
        check("nominal_fe", fe_seen, 0);

        // glitch
        rxd = 1'b0;
        wait_clks(3);
        rxd = 1'b1;
        wait_clks(40);
        check("glitch_busy", busy, 0);
        check("glitch_fe", fe_seen, 0);
        check("glitch_packet", packet, 32'h817E0180);

        // framing error then held-low break
        send_byte(8'hA5, 1'b0);
        wait_clks(100);
        check("break_busy", busy, 1);
        rxd = 1'b1;
        wait_clks(10);
        check("fe_count", fe_seen, 1);
        check("fe_busy", busy, 0);
        exp_q.push_back(32'h04030201);
        send_word(32'h04030201);
        wait_drain("fe_drain");

        // timeout resync
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        wait_clks(600);
        check("to_partial_busy", busy, 1);
        wait_clks(100);
        check("to_cleared_busy", busy, 0);
        exp_q.push_back(32'h04030201);
        send_word(32'h04030201);
        wait_drain("to_drain");

        // enable gating
        enable = 1'b0;
        send_byte(8'h5A, 1'b1);
        wait_clks(20);
        check("en_off_busy", busy, 0);
        enable = 1'b1;
        exp_q.push_back(32'h40302010);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h30, 1'b1);
        fork
            send_byte(8'h40, 1'b1);
            begin
                wait_clks(CPB * 4 + CPB / 2);
                enable = 1'b0;
            end
        join
        wait_drain("en_drop_drain");
        check("en_drop_packet", packet, 32'h40302010);
        enable = 1'b1;

        // reset mid-byte
        send_byte(8'hE1, 1'b1);
        send_partial(8'hE2, 5);
        rst_n = 1'b0;
        wait_clks(2);
        check("mid_rst_packet", packet, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", ready, 0);
        rxd = 1'b1;
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(4);
        exp_q.push_back(32'h0D0C0B0A);
        send_word(32'h0D0C0B0A);
        wait_drain("mid_rst_drain");

        wait_clks(20);
        check("final_fe_count", fe_seen, 1);
        check("final_busy", busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
